// File: rtl/uart_peripheral_pkg.sv
// Shared definitions for the lisp_core UART peripheral: register offsets,
// status bit positions and the TX/RX state encodings.
package uart_peripheral_pkg;

  localparam logic [6:0] REG_DATA_OFFSET   = 7'd0;
  localparam logic [6:0] REG_STATUS_OFFSET = 7'd1;

  localparam int ST_TX_READY   = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_peripheral_sync_fifo.sv
// Small synchronous FIFO for received UART bytes. Pointers carry an extra wrap
// bit so full and empty are told apart without a separate count.
module uart_peripheral_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push_s = push && (!full || do_pop_s);
  assign data_out  = mem_r[rd_ptr_r[AW-1:0]];

  // Read and write pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/uart_peripheral.sv
// 8N1 UART on the lisp_core register bus: data register (TX write / RX pop)
// and a status register with readiness and sticky error flags.
module uart_peripheral
  import uart_peripheral_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int BASE_INDEX     = 7,
  parameter int RX_FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int                BAUD_W    = $clog2(CLOCKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
  localparam logic [6:0]        DATA_IDX   = 7'(BASE_INDEX) + REG_DATA_OFFSET;
  localparam logic [6:0]        STATUS_IDX = 7'(BASE_INDEX) + REG_STATUS_OFFSET;

  logic data_sel_s, status_sel_s, wr_accept_s, data_read_s, status_read_s;
  logic hold_full_r, tx_take_s;
  logic [7:0] hold_data_r;
  tx_state_t tx_state_r, tx_state_n;
  logic [BAUD_W-1:0] tx_baud_r, tx_baud_n;
  logic [2:0] tx_bit_r, tx_bit_n;
  logic [7:0] tx_shift_r, tx_shift_n;
  logic tx_line_n;
  logic rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t rx_state_r, rx_state_n;
  logic [BAUD_W-1:0] rx_baud_r, rx_baud_n;
  logic [2:0] rx_bit_r, rx_bit_n;
  logic [7:0] rx_shift_r, rx_shift_n;
  logic rx_push_s, frame_set_s, overrun_set_s;
  logic frame_err_r, rx_overrun_r;
  logic fifo_empty_s, fifo_full_s;
  logic [7:0] fifo_data_s;
  logic [15:0] status_s, read_next_s;
  logic unused_s;

  assign unused_s      = &{1'b0, register_write_value[15:8]};
  assign data_sel_s    = (register_index == DATA_IDX);
  assign status_sel_s  = (register_index == STATUS_IDX);
  assign wr_accept_s   = register_write && data_sel_s && !hold_full_r;
  assign data_read_s   = register_read && data_sel_s;
  assign status_read_s = register_read && status_sel_s;
  assign overrun_set_s = rx_push_s && fifo_full_s && !data_read_s;

  uart_peripheral_sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push_s), .pop(data_read_s),
    .data_in(rx_shift_r), .data_out(fifo_data_s), .empty(fifo_empty_s), .full(fifo_full_s)
  );

  // Holding register between the bus and the TX shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_r <= 1'b0;
      hold_data_r <= 8'h00;
    end else if (tx_take_s) begin
      hold_full_r <= 1'b0;
    end else if (wr_accept_s) begin
      hold_full_r <= 1'b1;
      hold_data_r <= register_write_value[7:0];
    end
  end

  // TX next-state: each bit held for a full baud period, stop bit chains into the next start.
  always_comb begin
    tx_state_n = tx_state_r;
    tx_baud_n  = tx_baud_r;
    tx_bit_n   = tx_bit_r;
    tx_shift_n = tx_shift_r;
    tx_line_n  = uart_tx;
    tx_take_s  = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (hold_full_r) begin
          tx_take_s = 1'b1; tx_shift_n = hold_data_r; tx_baud_n = BAUD_LAST;
          tx_line_n = 1'b0; tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_baud_r == BAUD_ZERO) begin
          tx_state_n = TX_DATA; tx_baud_n = BAUD_LAST; tx_bit_n = 3'd0; tx_line_n = tx_shift_r[0];
        end else begin
          tx_baud_n = tx_baud_r - BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (tx_baud_r == BAUD_ZERO) begin
          tx_baud_n = BAUD_LAST;
          if (tx_bit_r == 3'd7) begin
            tx_state_n = TX_STOP; tx_line_n = 1'b1;
          end else begin
            tx_bit_n = tx_bit_r + 3'd1; tx_shift_n = {1'b0, tx_shift_r[7:1]}; tx_line_n = tx_shift_r[1];
          end
        end else begin
          tx_baud_n = tx_baud_r - BAUD_ONE;
        end
      end
      TX_STOP: begin
        if (tx_baud_r == BAUD_ZERO) begin
          if (hold_full_r) begin
            tx_take_s = 1'b1; tx_shift_n = hold_data_r; tx_baud_n = BAUD_LAST;
            tx_line_n = 1'b0; tx_state_n = TX_START;
          end else begin
            tx_line_n = 1'b1; tx_state_n = TX_IDLE;
          end
        end else begin
          tx_baud_n = tx_baud_r - BAUD_ONE;
        end
      end
      default: begin
        tx_state_n = TX_IDLE; tx_line_n = 1'b1;
      end
    endcase
  end

  // TX state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_r <= TX_IDLE; tx_baud_r <= BAUD_ZERO; tx_bit_r <= 3'd0;
      tx_shift_r <= 8'h00; uart_tx <= 1'b1;
    end else begin
      tx_state_r <= tx_state_n; tx_baud_r <= tx_baud_n; tx_bit_r <= tx_bit_n;
      tx_shift_r <= tx_shift_n; uart_tx <= tx_line_n;
    end
  end

  // Two-flop synchronizer plus previous sample for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1; rx_sync_r <= 1'b1; rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx; rx_sync_r <= rx_meta_r; rx_prev_r <= rx_sync_r;
    end
  end

  // RX next-state: re-arming needs a fresh falling edge, so a low line after a bad stop bit waits.
  always_comb begin
    rx_state_n  = rx_state_r;
    rx_baud_n   = rx_baud_r;
    rx_bit_n    = rx_bit_r;
    rx_shift_n  = rx_shift_r;
    rx_push_s   = 1'b0;
    frame_set_s = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_n = RX_START; rx_baud_n = BAUD_HALF;
        end else begin
          rx_state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_baud_r == BAUD_ZERO) begin
          if (rx_sync_r) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA; rx_baud_n = BAUD_LAST; rx_bit_n = 3'd0;
          end
        end else begin
          rx_baud_n = rx_baud_r - BAUD_ONE;
        end
      end
      RX_DATA: begin
        if (rx_baud_r == BAUD_ZERO) begin
          rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
          rx_baud_n  = BAUD_LAST;
          if (rx_bit_r == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit_r + 3'd1;
          end
        end else begin
          rx_baud_n = rx_baud_r - BAUD_ONE;
        end
      end
      RX_STOP: begin
        if (rx_baud_r == BAUD_ZERO) begin
          rx_state_n = RX_IDLE;
          if (rx_sync_r) begin
            rx_push_s = 1'b1;
          end else begin
            frame_set_s = 1'b1;
          end
        end else begin
          rx_baud_n = rx_baud_r - BAUD_ONE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r <= RX_IDLE; rx_baud_r <= BAUD_ZERO; rx_bit_r <= 3'd0; rx_shift_r <= 8'h00;
    end else begin
      rx_state_r <= rx_state_n; rx_baud_r <= rx_baud_n; rx_bit_r <= rx_bit_n; rx_shift_r <= rx_shift_n;
    end
  end

  // Sticky error flags: a status read clears them unless a new event lands in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_r  <= 1'b0;
      rx_overrun_r <= 1'b0;
    end else begin
      frame_err_r  <= frame_set_s | (frame_err_r & ~status_read_s);
      rx_overrun_r <= overrun_set_s | (rx_overrun_r & ~status_read_s);
    end
  end

  // Register read mux; the result holds until the next read strobe.
  always_comb begin
    status_s = 16'h0000;
    status_s[ST_TX_READY]   = !hold_full_r;
    status_s[ST_RX_VALID]   = !fifo_empty_s;
    status_s[ST_RX_OVERRUN] = rx_overrun_r;
    status_s[ST_FRAME_ERR]  = frame_err_r;
    read_next_s = register_read_value;
    if (register_read) begin
      if (data_sel_s) begin
        read_next_s = {8'h00, (fifo_empty_s ? 8'h00 : fifo_data_s)};
      end else if (status_sel_s) begin
        read_next_s = status_s;
      end else begin
        read_next_s = 16'h0000;
      end
    end else begin
      read_next_s = register_read_value;
    end
  end

  // Registered bus read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      register_read_value <= 16'h0000;
    end else begin
      register_read_value <= read_next_s;
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// Self-checking bench for uart_peripheral: directed scenarios plus randomized
// TX/RX traffic compared against a queue-based model of the register interface.
module tb_uart_peripheral;

  localparam int CPB   = 8;
  localparam int BASE  = 7;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  register_index = 7'd0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = 16'h0000;
  logic [15:0] register_read_value;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned rx_q[$];
  bit m_overrun = 1'b0;
  bit m_frame   = 1'b0;

  always #5 clk = ~clk;

  uart_peripheral #(.CLOCKS_PER_BIT(CPB), .BASE_INDEX(BASE), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .register_index(register_index),
    .register_read(register_read), .register_write(register_write),
    .register_write_value(register_write_value), .register_read_value(register_read_value),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [6:0] idx, input logic [15:0] val);
    register_index = idx; register_write_value = val; register_write = 1'b1;
    @(posedge clk); #1;
    register_write = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] idx, output logic [15:0] val);
    register_index = idx; register_read = 1'b1;
    @(posedge clk); #1;
    register_read = 1'b0;
    val = register_read_value;
  endtask

  // Waits up to max_wait cycles for a start bit, then records one frame cycle by cycle.
  task automatic tx_capture(input int max_wait, output int waited, output logic [79:0] wave);
    waited = -1;
    wave = '0;
    for (int i = 0; i <= max_wait; i++) begin
      if (uart_tx === 1'b0) begin waited = i; break; end
      @(posedge clk); #1;
    end
    if (waited >= 0) begin
      for (int c = 0; c < 10 * CPB; c++) begin
        wave[c] = uart_tx;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic count_tx_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (uart_tx !== 1'b1) lows++;
      @(posedge clk); #1;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] frame_wave(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    frame_wave = '0;
    for (int c = 0; c < 10 * CPB; c++) frame_wave[c] = bits[c / CPB];
  endfunction

  function automatic logic [15:0] model_status(input bit tx_ready);
    return {12'd0, m_frame, m_overrun, (rx_q.size() != 0), tx_ready};
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_overrun = 1'b1;
  endtask

  task automatic model_pop(output logic [15:0] v);
    if (rx_q.size() != 0) v = {8'd0, rx_q.pop_front()};
    else v = 16'h0000;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (uart_tx !== 1'b1 || register_read_value !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs: got tx=%b rd=%h expected tx=1 rd=0000", uart_tx, register_read_value);
    end
    reset_n = 1'b1;
    bus_read(7'(BASE + 1), rd);
    n_checks++;
    if (rd !== 16'h0001) begin n_fail++; $display("FAIL reset_status: got %h expected 0001", rd); end
    bus_read(7'(BASE), rd);
    n_checks++;
    if (rd !== 16'h0000 || uart_tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_data: got rd=%h tx=%b expected 0000 tx=1", rd, uart_tx);
    end
    bus_read(7'(BASE + 1), rd);
    bus_read(7'd3, rd);
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL other_index: got %h expected 0000", rd); end
  endtask

  task automatic test_tx_single();
    logic [15:0] s1, s2;
    int w;
    logic [79:0] wv;
    bus_write(7'(BASE), 16'h0155);
    fork
      tx_capture(2, w, wv);
      begin bus_read(7'(BASE + 1), s1); bus_read(7'(BASE + 1), s2); end
    join
    n_checks++;
    if (w < 0 || w > 2) begin n_fail++; $display("FAIL tx_start_latency: got %0d expected 0..2", w); end
    n_checks++;
    if (wv !== frame_wave(8'h55)) begin n_fail++; $display("FAIL tx_frame_55: got %h expected %h", wv, frame_wave(8'h55)); end
    n_checks++;
    if (s1 !== 16'h0000 || s2 !== 16'h0001) begin
      n_fail++; $display("FAIL tx_ready_status: got %h,%h expected 0000,0001", s1, s2);
    end
  endtask

  task automatic test_tx_back_to_back();
    logic [15:0] s;
    int w1, w2, lows;
    logic [79:0] wv1, wv2;
    bus_write(7'(BASE), 16'h0012);
    fork
      tx_capture(2, w1, wv1);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus_write(7'(BASE), 16'h0034);
        bus_write(7'(BASE), 16'h0056);
        bus_read(7'(BASE + 1), s);
      end
    join
    tx_capture(0, w2, wv2);
    count_tx_low(100, lows);
    n_checks++;
    if (w1 < 0 || w1 > 2 || wv1 !== frame_wave(8'h12)) begin
      n_fail++; $display("FAIL b2b_frame1: got wait=%0d wave=%h expected %h", w1, wv1, frame_wave(8'h12));
    end
    n_checks++;
    if (w2 !== 0 || wv2 !== frame_wave(8'h34)) begin
      n_fail++; $display("FAIL b2b_frame2: got wait=%0d wave=%h expected wait=0 %h", w2, wv2, frame_wave(8'h34));
    end
    n_checks++;
    if (s !== 16'h0000) begin n_fail++; $display("FAIL b2b_holding_status: got %h expected 0000", s); end
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL b2b_no_third_frame: got %0d low cycles expected 0", lows); end
    bus_read(7'(BASE + 1), s);
    n_checks++;
    if (s !== 16'h0001) begin n_fail++; $display("FAIL b2b_final_status: got %h expected 0001", s); end
  endtask

  task automatic test_rx_single();
    logic [15:0] rd, exp;
    rx_send(8'hA3, 1'b1);
    model_push(8'hA3);
    bus_read(7'(BASE + 1), rd);
    exp = model_status(1'b1); m_frame = 1'b0; m_overrun = 1'b0;
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rx_status_valid: got %h expected %h", rd, exp); end
    bus_read(7'(BASE), rd);
    model_pop(exp);
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rx_data_a3: got %h expected %h", rd, exp); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (register_read_value !== exp) begin
      n_fail++; $display("FAIL read_hold: got %h expected %h", register_read_value, exp);
    end
    bus_read(7'(BASE + 1), rd);
    exp = model_status(1'b1);
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rx_status_drained: got %h expected %h", rd, exp); end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] rd, exp;
    for (int v = 1; v <= 5; v++) begin
      rx_send(8'(v), 1'b1);
      model_push(8'(v));
    end
    for (int k = 0; k < 2; k++) begin
      bus_read(7'(BASE + 1), rd);
      exp = model_status(1'b1); m_frame = 1'b0; m_overrun = 1'b0;
      n_checks++;
      if (rd !== exp) begin n_fail++; $display("FAIL overrun_status_%0d: got %h expected %h", k, rd, exp); end
    end
    for (int k = 0; k < 5; k++) begin
      bus_read(7'(BASE), rd);
      model_pop(exp);
      n_checks++;
      if (rd !== exp) begin n_fail++; $display("FAIL overrun_data_%0d: got %h expected %h", k, rd, exp); end
    end
  endtask

  task automatic test_rx_errors();
    logic [15:0] rd, exp;
    rx_send(8'h5A, 1'b0);
    m_frame = 1'b1;
    bus_read(7'(BASE + 1), rd);
    exp = model_status(1'b1); m_frame = 1'b0; m_overrun = 1'b0;
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL frame_err_status: got %h expected %h", rd, exp); end
    bus_read(7'(BASE), rd);
    model_pop(exp);
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL frame_err_no_data: got %h expected %h", rd, exp); end
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    bus_read(7'(BASE + 1), rd);
    exp = model_status(1'b1);
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL glitch_status: got %h expected %h", rd, exp); end
    bus_read(7'(BASE), rd);
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL glitch_data: got %h expected 0000", rd); end
  endtask

  task automatic test_reset_mid_tx();
    logic [15:0] rd;
    int lows;
    bus_write(7'(BASE), 16'h0000);
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_tx_line_low: got %b expected 0", uart_tx); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_abort_tx: got %b expected 1", uart_tx); end
    rx_q.delete(); m_frame = 1'b0; m_overrun = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    count_tx_low(100, lows);
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL reset_no_partial: got %0d low cycles expected 0", lows); end
    bus_read(7'(BASE + 1), rd);
    n_checks++;
    if (rd !== model_status(1'b1)) begin n_fail++; $display("FAIL reset_tx_ready: got %h expected %h", rd, model_status(1'b1)); end
  endtask

  task automatic test_random();
    logic [15:0] rd, exp;
    logic [7:0] tb_b, rb;
    int w;
    logic [79:0] wv;
    for (int it = 0; it < 8; it++) begin
      tb_b = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      fork
        begin
          bus_write(7'(BASE), {8'($urandom_range(0, 255)), tb_b});
          tx_capture(2, w, wv);
        end
        rx_send(rb, 1'b1);
      join
      model_push(rb);
      n_checks++;
      if (w < 0 || w > 2 || wv !== frame_wave(tb_b)) begin
        n_fail++; $display("FAIL rand_tx_%0d: got wait=%0d wave=%h expected %h", it, w, wv, frame_wave(tb_b));
      end
      if ($urandom_range(0, 1) == 1) begin
        bus_read(7'(BASE + 1), rd);
        exp = model_status(1'b1); m_frame = 1'b0; m_overrun = 1'b0;
        n_checks++;
        if (rd !== exp) begin n_fail++; $display("FAIL rand_status_%0d: got %h expected %h", it, rd, exp); end
      end
      if ($urandom_range(0, 2) != 0) begin
        bus_read(7'(BASE), rd);
        model_pop(exp);
        n_checks++;
        if (rd !== exp) begin n_fail++; $display("FAIL rand_data_%0d: got %h expected %h", it, rd, exp); end
      end
    end
    bus_read(7'(BASE + 1), rd);
    exp = model_status(1'b1); m_frame = 1'b0; m_overrun = 1'b0;
    n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL rand_final_status: got %h expected %h", rd, exp); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      bus_read(7'(BASE), rd);
      model_pop(exp);
      n_checks++;
      if (rd !== exp) begin n_fail++; $display("FAIL rand_drain_%0d: got %h expected %h", k, rd, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_back_to_back();
    test_rx_single();
    test_rx_overrun();
    test_rx_errors();
    test_reset_mid_tx();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
